balun_port_power_meter: RTL and testbench

//  Digital power meter sitting directly downstream of the balun/LPF measurement chain.

---
 rtl/balun_port_power_meter_if.sv | 26 ++
 rtl/balun_port_power_meter.sv | 151 +++++++++++++++
 tb/tb_balun_port_power_meter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/balun_port_power_meter_if.sv
// Sample-pair stream in, power result stream out, for the balun port power meter.
// Both streams use valid/ready handshakes.
interface balun_port_power_meter_if #(
    parameter int W     = 12,
    parameter int LOG2N = 10
);
    logic                   s_valid;
    logic                   s_ready;
    logic [W-1:0]           s_a;
    logic [W-1:0]           s_b;
    logic                   m_valid;
    logic                   m_ready;
    logic [2*W+LOG2N-1:0]   m_pa;
    logic [2*W+LOG2N-1:0]   m_pb;
    logic                   m_clip;

    modport master (
        output s_valid, s_a, s_b, m_ready,
        input  s_ready, m_valid, m_pa, m_pb, m_clip
    );

    modport slave (
        input  s_valid, s_a, s_b, m_ready,
        output s_ready, m_valid, m_pa, m_pb, m_clip
    );
endinterface

// File: rtl/balun_port_power_meter.sv
// Windowed sum-of-squares power meter for the incident and transmitted balun ports.
// Software forms |S21|^2 from the two sums; clipping is flagged per window.
module balun_port_power_meter #(
    parameter int W     = 12,
    parameter int LOG2N = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    balun_port_power_meter_if.slave bus
);
    localparam int AW = 2 * W + LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = '1;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             s_ready;
    logic             m_valid;
    logic             xfer;
    logic             last;
    logic             done_hs;

    logic [LOG2N-1:0] cnt_q;
    logic [AW-1:0]    acc_a_q;
    logic [AW-1:0]    acc_b_q;
    logic             clip_q;
    logic [AW-1:0]    pa_q;
    logic [AW-1:0]    pb_q;
    logic             mclip_q;

    logic signed [2*W-1:0] a_x;
    logic signed [2*W-1:0] b_x;
    logic signed [2*W-1:0] prod_a;
    logic signed [2*W-1:0] prod_b;
    logic [AW-1:0]    sq_a;
    logic [AW-1:0]    sq_b;
    logic [AW-1:0]    sum_a;
    logic [AW-1:0]    sum_b;
    logic             clip_hit;

    // Squares are never negative, so the 2W-bit product zero-extends safely.
    assign a_x    = {{W{bus.s_a[W-1]}}, bus.s_a};
    assign b_x    = {{W{bus.s_b[W-1]}}, bus.s_b};
    assign prod_a = a_x * a_x;
    assign prod_b = b_x * b_x;
    assign sq_a   = {{LOG2N{1'b0}}, unsigned'(prod_a)};
    assign sq_b   = {{LOG2N{1'b0}}, unsigned'(prod_b)};
    assign sum_a  = acc_a_q + sq_a;
    assign sum_b  = acc_b_q + sq_b;

    assign clip_hit = (bus.s_a == MAX_POS) || (bus.s_a == MIN_NEG)
                   || (bus.s_b == MAX_POS) || (bus.s_b == MIN_NEG);

    assign xfer    = bus.s_valid && s_ready;
    assign last    = xfer && (cnt_q == CNT_LAST);
    assign done_hs = (state_q == DONE) && bus.m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            ACC: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                m_valid = 1'b1;
                busy    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Counter wraps to zero on the last transfer, ready for the next window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            clip_q  <= 1'b0;
            pa_q    <= '0;
            pb_q    <= '0;
            mclip_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            clip_q  <= 1'b0;
        end else if (xfer) begin
            cnt_q   <= cnt_q + 1'b1;
            acc_a_q <= sum_a;
            acc_b_q <= sum_b;
            clip_q  <= clip_q | clip_hit;
            if (last) begin
                pa_q    <= sum_a;
                pb_q    <= sum_b;
                mclip_q <= clip_q | clip_hit;
            end
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_pa    = pa_q;
    assign bus.m_pb    = pb_q;
    assign bus.m_clip  = mclip_q;
endmodule

// File: tb/tb_balun_port_power_meter.sv
// Directed bench for the balun port power meter: small window for the
// hand-computed cases, full 1024-sample window against a reference model.
module tb_balun_port_power_meter;
    logic clk = 1'b0;
    logic rst_n;
    logic start0;
    logic start1;
    logic busy0;
    logic busy1;

    int total = 0;
    int bad   = 0;

    balun_port_power_meter_if #(.W(12), .LOG2N(2))  bus0 ();
    balun_port_power_meter_if #(.W(12), .LOG2N(10)) bus1 ();

    balun_port_power_meter #(.W(12), .LOG2N(2)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .busy  (busy0),
        .bus   (bus0)
    );

    balun_port_power_meter #(.W(12), .LOG2N(10)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .busy  (busy1),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input int a, input int b);
        bus0.s_valid = v;
        bus0.s_a     = 12'(a);
        bus0.s_b     = 12'(b);
    endtask

    task automatic hs0();
        bus0.m_ready = 1'b1;
        step();
        bus0.m_ready = 1'b0;
        chk("hs0_mvalid_low", 64'(bus0.m_valid), 64'd0);
        chk("hs0_busy_low", 64'(busy0), 64'd0);
    endtask

    task automatic window0(input int a, input int b);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        drive0(1'b1, a, b);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        drive0(1'b0, 0, 0);
    endtask

    initial begin
        logic signed [11:0] ra;
        logic signed [11:0] rb;
        longint exp_pa;
        longint exp_pb;
        logic   exp_clip;
        int     n;
        int     guard;

        rst_n        = 1'b0;
        start0       = 1'b0;
        start1       = 1'b0;
        bus0.m_ready = 1'b0;
        bus1.m_ready = 1'b0;
        bus1.s_valid = 1'b0;
        bus1.s_a     = '0;
        bus1.s_b     = '0;
        drive0(1'b0, 0, 0);
        step();
        step();

        chk("rst_sready", 64'(bus0.s_ready), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_mvalid", 64'(bus0.m_valid), 64'd0);
        chk("rst_pa", 64'(bus0.m_pa), 64'd0);
        chk("rst_pb", 64'(bus0.m_pb), 64'd0);
        chk("rst_clip", 64'(bus0.m_clip), 64'd0);
        rst_n = 1'b1;

        // 4 pairs a=100, b=50 back to back; check latency edge by edge.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("t1_sready", 64'(bus0.s_ready), 64'd1);
        chk("t1_busy", 64'(busy0), 64'd1);
        drive0(1'b1, 100, 50);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_mvalid_early", 64'(bus0.m_valid), 64'd0);
        end
        step();
        drive0(1'b0, 0, 0);
        chk("t1_mvalid", 64'(bus0.m_valid), 64'd1);
        chk("t1_sready_done", 64'(bus0.s_ready), 64'd0);
        chk("t1_pa", 64'(bus0.m_pa), 64'd40000);
        chk("t1_pb", 64'(bus0.m_pb), 64'd10000);
        chk("t1_clip", 64'(bus0.m_clip), 64'd0);
        hs0();
        chk("t1_pa_kept", 64'(bus0.m_pa), 64'd40000);

        // Full scale on both channels.
        window0(-2048, 2047);
        chk("t2_mvalid", 64'(bus0.m_valid), 64'd1);
        chk("t2_pa", 64'(bus0.m_pa), 64'd16777216);
        chk("t2_pb", 64'(bus0.m_pb), 64'd16760836);
        chk("t2_clip", 64'(bus0.m_clip), 64'd1);

        // Backpressure with stray start and samples while DONE.
        start0 = 1'b1;
        drive0(1'b1, 5, 5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_mvalid", 64'(bus0.m_valid), 64'd1);
            chk("t3_pa", 64'(bus0.m_pa), 64'd16777216);
            chk("t3_sready", 64'(bus0.s_ready), 64'd0);
        end
        start0 = 1'b0;
        drive0(1'b0, 0, 0);
        hs0();
        chk("t3_pa_kept", 64'(bus0.m_pa), 64'd16777216);
        chk("t3_idle_sready", 64'(bus0.s_ready), 64'd0);

        // Alternating valid gaps.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive0((i % 2) == 0, 3, -4);
            step();
        end
        drive0(1'b0, 0, 0);
        chk("t4_mvalid", 64'(bus0.m_valid), 64'd1);
        chk("t4_pa", 64'(bus0.m_pa), 64'd36);
        chk("t4_pb", 64'(bus0.m_pb), 64'd64);
        chk("t4_clip", 64'(bus0.m_clip), 64'd0);
        hs0();

        // Reset after two pairs, then a clean window.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        drive0(1'b1, 7, 7);
        step();
        step();
        drive0(1'b0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_busy", 64'(busy0), 64'd0);
        chk("t5_sready", 64'(bus0.s_ready), 64'd0);
        chk("t5_mvalid", 64'(bus0.m_valid), 64'd0);
        chk("t5_pa", 64'(bus0.m_pa), 64'd0);
        chk("t5_pb", 64'(bus0.m_pb), 64'd0);
        chk("t5_clip", 64'(bus0.m_clip), 64'd0);
        window0(1, 1);
        chk("t5_mvalid2", 64'(bus0.m_valid), 64'd1);
        chk("t5_pa2", 64'(bus0.m_pa), 64'd4);
        chk("t5_pb2", 64'(bus0.m_pb), 64'd4);
        chk("t5_clip2", 64'(bus0.m_clip), 64'd0);
        hs0();

        // 50 random windows of 1024 pairs with occasional gaps.
        for (int w = 0; w < 50; w++) begin
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            exp_pa   = 0;
            exp_pb   = 0;
            exp_clip = 1'b0;
            n        = 0;
            guard    = 0;
            while (n < 1024 && guard < 4096) begin
                ra = 12'($urandom_range(0, 4095));
                rb = 12'($urandom_range(0, 4095));
                bus1.s_a     = ra;
                bus1.s_b     = rb;
                bus1.s_valid = ($urandom_range(0, 7) != 0);
                if (bus1.s_valid) begin
                    exp_pa += longint'(ra) * longint'(ra);
                    exp_pb += longint'(rb) * longint'(rb);
                    if (ra == -12'sd2048 || ra == 12'sd2047 ||
                        rb == -12'sd2048 || rb == 12'sd2047) begin
                        exp_clip = 1'b1;
                    end
                    n++;
                end
                guard++;
                step();
            end
            bus1.s_valid = 1'b0;
            chk("t6_mvalid", 64'(bus1.m_valid), 64'd1);
            chk("t6_pa", 64'(bus1.m_pa), 64'(exp_pa));
            chk("t6_pb", 64'(bus1.m_pb), 64'(exp_pb));
            chk("t6_clip", 64'(bus1.m_clip), 64'(exp_clip));
            bus1.m_ready = 1'b1;
            step();
            bus1.m_ready = 1'b0;
            chk("t6_mvalid_low", 64'(bus1.m_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
